// File: rtl/aes128_iter_encryptor.sv
// Iterative AES-128 encryptor: initial AddRoundKey on start, then one round per clock
// with the round key expanded on the fly. Byte 0 is bits [127:120], state is column-major.
module aes128_iter_encryptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         done,
    output logic         busy
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the [02 03 01 01] circulant; 03*a is xtime(a)^a.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;

    logic [127:0] sub_rows;
    logic [127:0] mixed;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_word;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [127:0] rkey_next;

    // Destination byte (row r, col c) reads source byte (row r, col (c+r)%4).
    always_comb begin
        sub_rows = '0;
        for (int i = 0; i < 16; i++) begin
            sub_rows[127 - 8*i -: 8] =
                sbox(state_q[127 - 8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]);
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_col(sub_rows[127 - 32*c -: 32]);
        end
    end

    always_comb begin
        rot_w3    = {rkey_q[23:0], rkey_q[31:24]};
        sub_word  = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
        w0n       = rkey_q[127:96] ^ sub_word ^ {rcon_q, 24'h000000};
        w1n       = rkey_q[95:64] ^ w0n;
        w2n       = rkey_q[63:32] ^ w1n;
        w3n       = rkey_q[31:0]  ^ w2n;
        rkey_next = {w0n, w1n, w2n, w3n};
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d   = RUN;
                    state_d = plaintext ^ key;
                    rkey_d  = key;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                end
            end
            RUN: begin
                rkey_d = rkey_next;
                rcon_d = xtime(rcon_q);
                if (round_q == 4'd10) begin
                    state_d = sub_rows ^ rkey_next;
                    ct_d    = sub_rows ^ rkey_next;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else begin
                    state_d = mixed ^ rkey_next;
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign ciphertext = ct_q;
    assign done       = done_q;
    assign busy       = (fsm_q == RUN);

endmodule
